// File: rtl/fibre_delay_ring_if.sv
// fibre_delay_ring_if
//   Bundles the splitter-side word stream into the delay ring together with
//   the delayed replay stream and status coming back out of it.
//
//   Inputs to the ring (driven by master):
//     i_start   one-cycle restart pulse
//     i_data    word to store
//     i_addr    write address from the splitter
//     i_en      write strobe
//   Outputs of the ring (driven by slave):
//     o_data    delayed word
//     o_en      o_data valid (single-cycle pulse per read)
//     o_addr    ring address o_data was read from
//     o_level   words currently buffered
//     o_running ring is replaying
//     o_err     sticky write-address discontinuity flag
interface fibre_delay_ring_if #(
  parameter int DATA_WIDTH   = 60,
  parameter int W_ADDR_WIDTH = 14
);
  logic                    i_start;
  logic [DATA_WIDTH-1:0]   i_data;
  logic [W_ADDR_WIDTH-1:0] i_addr;
  logic                    i_en;
  logic [DATA_WIDTH-1:0]   o_data;
  logic                    o_en;
  logic [W_ADDR_WIDTH-1:0] o_addr;
  logic [W_ADDR_WIDTH:0]   o_level;
  logic                    o_running;
  logic                    o_err;

  modport master (
    output i_start, i_data, i_addr, i_en,
    input  o_data, o_en, o_addr, o_level, o_running, o_err
  );

  modport slave (
    input  i_start, i_data, i_addr, i_en,
    output o_data, o_en, o_addr, o_level, o_running, o_err
  );
endinterface

// File: rtl/fibre_delay_ring.sv
// fibre_delay_ring
//   Circular delay buffer fed by the width splitter. Each accepted word is
//   stored in a RAM ring spanning WR_START_ADDR .. WR_START_ADDR+
//   FIBRE_DELAY_CLK_NUM-1. After DELAY_WORDS words have been buffered every
//   further write is paired with a read, so the stream is replayed in write
//   order exactly DELAY_WORDS words late. Write addresses are checked for
//   contiguity against an internally tracked write pointer.
//
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    fibre_delay_ring_if.slave (stream in, delayed stream and
//            status out)
module fibre_delay_ring #(
  parameter int DATA_WIDTH          = 60,
  parameter int W_ADDR_WIDTH        = 14,
  parameter int WR_START_ADDR       = 0,
  parameter int FIBRE_DELAY_CLK_NUM = 1024,
  parameter int DELAY_WORDS         = 1000
) (
  input logic               clk,
  input logic               rst_n,
  fibre_delay_ring_if.slave bus
);

  localparam int MEM_DEPTH = 1 << W_ADDR_WIDTH;
  localparam int LAST_I    = WR_START_ADDR + FIBRE_DELAY_CLK_NUM - 1;

  localparam logic [W_ADDR_WIDTH-1:0] RING_FIRST = WR_START_ADDR[W_ADDR_WIDTH-1:0];
  localparam logic [W_ADDR_WIDTH-1:0] RING_LAST  = LAST_I[W_ADDR_WIDTH-1:0];
  localparam logic [W_ADDR_WIDTH:0]   DELAY_LVL  = DELAY_WORDS[W_ADDR_WIDTH:0];

  if ((DELAY_WORDS < 1) || (DELAY_WORDS > FIBRE_DELAY_CLK_NUM) ||
      (WR_START_ADDR + FIBRE_DELAY_CLK_NUM > MEM_DEPTH)) begin : g_bad_params
    $error("fibre_delay_ring: inconsistent ring/delay parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Wrap by comparing against the last ring address rather than a modulo,
  // so the ring need not be a power of two.
  function automatic logic [W_ADDR_WIDTH-1:0] nxt_ptr(input logic [W_ADDR_WIDTH-1:0] p);
    return (p == RING_LAST) ? RING_FIRST : p + 1'b1;
  endfunction

  state_t                  state_q, state_d;
  logic [W_ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [W_ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [W_ADDR_WIDTH:0]   level_q, level_d;
  logic                    err_q, err_d;

  logic                    wr_p0;
  logic                    rd_p0;

  logic [DATA_WIDTH-1:0]   mem [0:MEM_DEPTH-1];

  logic [DATA_WIDTH-1:0]   data_p1;
  logic [W_ADDR_WIDTH-1:0] addr_p1;
  logic                    vld_p1;

  // ---- stage p0: accept decision, pointer/level/flag update ----
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    err_d   = err_q;
    wr_p0   = 1'b0;
    rd_p0   = 1'b0;

    if (bus.i_start) begin
      // Restart wins over a coincident write; any read that would have been
      // paired with it is never issued, so o_en is low next cycle.
      state_d = S_FILL;
      wp_d    = RING_FIRST;
      rp_d    = RING_FIRST;
      level_d = '0;
      err_d   = 1'b0;
    end else if (bus.i_en && (state_q != S_IDLE)) begin
      wr_p0 = 1'b1;
      // A discontinuous address is flagged but still written where the
      // splitter asked; wp keeps counting so later words line up again.
      wp_d  = nxt_ptr(wp_q);
      if (bus.i_addr != wp_q) begin
        err_d = 1'b1;
      end
      if (state_q == S_FILL) begin
        level_d = level_q + 1'b1;
        if (level_d == DELAY_LVL) begin
          state_d = S_RUN;
        end
      end else begin
        rd_p0 = 1'b1;
        rp_d  = nxt_ptr(rp_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wp_q    <= RING_FIRST;
      rp_q    <= RING_FIRST;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Ring storage. The read below samples mem in the same edge as this write,
  // so a colliding read (full-ring delay) returns the old word.
  always_ff @(posedge clk) begin
    if (wr_p0) begin
      mem[bus.i_addr] <= bus.i_data;
    end
  end

  // ---- stage p1: registered read data and its address ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      addr_p1 <= RING_FIRST;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_p0;
      if (rd_p0) begin
        data_p1 <= mem[rp_q];
        addr_p1 <= rp_q;
      end
    end
  end

  assign bus.o_data    = data_p1;
  assign bus.o_en      = vld_p1;
  assign bus.o_addr    = addr_p1;
  assign bus.o_level   = level_q;
  assign bus.o_running = (state_q == S_RUN);
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_fibre_delay_ring.sv
// tb_fibre_delay_ring
//   Two rings (DELAY_WORDS=5 and DELAY_WORDS=8 on an 8-word ring at address
//   4) driven with identical stimulus and compared every cycle against a
//   write-count based reference model.
module tb_fibre_delay_ring;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int START = 4;
  localparam int N     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fibre_delay_ring_if #(.DATA_WIDTH(DW), .W_ADDR_WIDTH(AW)) bus0 ();
  fibre_delay_ring_if #(.DATA_WIDTH(DW), .W_ADDR_WIDTH(AW)) bus1 ();

  fibre_delay_ring #(.DATA_WIDTH(DW), .W_ADDR_WIDTH(AW), .WR_START_ADDR(START),
                     .FIBRE_DELAY_CLK_NUM(N), .DELAY_WORDS(5))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  fibre_delay_ring #(.DATA_WIDTH(DW), .W_ADDR_WIDTH(AW), .WR_START_ADDR(START),
                     .FIBRE_DELAY_CLK_NUM(N), .DELAY_WORDS(8))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: everything derives from the number of words written
  // since the last restart.
  int         dly [2] = '{5, 8};
  bit         m_act [2];
  int         m_cnt [2];
  logic [7:0] m_mem [2][32];
  bit         e_en [2];
  logic [7:0] e_data [2];
  int         e_addr [2];
  int         e_level [2];
  bit         e_run [2];
  bit         e_err [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_cnt[d] = 0; e_en[d] = 0; e_data[d] = 0;
      e_addr[d] = START; e_level[d] = 0; e_run[d] = 0; e_err[d] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit e, input int a, input int dat);
    for (int d = 0; d < 2; d++) begin
      if (s) begin
        m_act[d] = 1; m_cnt[d] = 0; e_err[d] = 0; e_en[d] = 0;
        e_level[d] = 0; e_run[d] = 0;
      end else if (m_act[d] && e) begin
        e_en[d] = (m_cnt[d] >= dly[d]);
        if (e_en[d]) begin
          e_addr[d] = START + ((m_cnt[d] - dly[d]) % N);
          e_data[d] = m_mem[d][e_addr[d]];
        end
        if (a != START + (m_cnt[d] % N)) e_err[d] = 1;
        m_mem[d][a] = dat[7:0];
        m_cnt[d]++;
        e_level[d] = (m_cnt[d] < dly[d]) ? m_cnt[d] : dly[d];
        e_run[d]   = (m_cnt[d] >= dly[d]);
      end else begin
        e_en[d] = 0;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic en, input logic [7:0] data,
                           input logic [4:0] addr, input logic [5:0] lvl,
                           input logic run, input logic err, input bit full);
    check_val($sformatf("d%0d_en", d), en, e_en[d]);
    if (e_en[d] || full) begin
      check_val($sformatf("d%0d_data", d), data, e_data[d]);
      check_val($sformatf("d%0d_addr", d), addr, e_addr[d]);
    end
    check_val($sformatf("d%0d_level", d), lvl, e_level[d]);
    check_val($sformatf("d%0d_running", d), run, e_run[d]);
    check_val($sformatf("d%0d_err", d), err, e_err[d]);
  endtask

  task automatic check_all(input bit full);
    check_dut(0, bus0.o_en, bus0.o_data, bus0.o_addr, bus0.o_level, bus0.o_running, bus0.o_err, full);
    check_dut(1, bus1.o_en, bus1.o_data, bus1.o_addr, bus1.o_level, bus1.o_running, bus1.o_err, full);
    if (bus0.o_en) q0.push_back(bus0.o_data);
    if (bus1.o_en) q1.push_back(bus1.o_data);
  endtask

  task automatic drive(input bit s, input bit e, input int a, input int dat);
    bus0.i_start = s; bus0.i_en = e; bus0.i_addr = a[4:0]; bus0.i_data = dat[7:0];
    bus1.i_start = s; bus1.i_en = e; bus1.i_addr = a[4:0]; bus1.i_data = dat[7:0];
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check 1ns later.
  task automatic step(input bit s, input bit e, input int a, input int dat);
    drive(s, e, a, dat);
    @(posedge clk);
    model_step(s, e, a, dat);
    #1;
    check_all(1'b0);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse: outputs must clear without waiting for an edge.
  task automatic do_reset();
    drive(0, 1, START, 8'hAA);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(1'b1);
    @(posedge clk);
    #1;
    check_all(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_queue(input string tag, input int d, input int n);
    int sz;
    sz = (d == 0) ? q0.size() : q1.size();
    check_val({tag, "_count"}, sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      check_val($sformatf("%s_word%0d", tag, i), (d == 0) ? q0[i] : q1[i], i + 1);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    do_reset();

    // IDLE ignores writes
    for (int k = 0; k < 3; k++) step(0, 1, START + k, k + 1);

    // Touch every RAM address once so no later read sees uninitialised data
    step(1, 0, 0, 0);
    for (int k = 0; k < 32; k++) step(0, 1, k, $urandom_range(0, 255));

    // Basic delay
    step(1, 0, 0, 0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 10; k++) step(0, 1, START + (k % N), k + 1);
    check_queue("basic", 0, 5);

    // Gapped input
    step(1, 0, 0, 0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 10; k++) begin
      step(0, 1, START + (k % N), k + 1);
      step(0, 0, 0, 0);
    end
    check_queue("gapped", 0, 5);

    // Full-ring collision on the DELAY_WORDS=8 ring
    step(1, 0, 0, 0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 16; k++) step(0, 1, START + (k % N), k + 1);
    check_queue("collide", 1, 8);

    // Address error: 4,5,7 then more writes, then restart clears it
    step(1, 0, 0, 0);
    step(0, 1, 4, 11);
    step(0, 1, 5, 12);
    step(0, 1, 7, 13);
    for (int k = 0; k < 4; k++) step(0, 1, START + ((k + 3) % N), 20 + k);
    step(1, 0, 0, 0);

    // Restart mid-RUN with a coincident write
    for (int k = 0; k < 7; k++) step(0, 1, START + (k % N), 30 + k);
    step(1, 1, START + 7, 99);
    for (int k = 0; k < 6; k++) step(0, 1, START + (k % N), 40 + k);

    // Reset mid-stream, writes ignored until restart
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 1, START + k, 50 + k);
    step(1, 0, 0, 0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      int a;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        step(1, 0, 0, 0);
      end else begin
        a = START + (m_cnt[0] % N);
        if ($urandom_range(0, 49) == 0) a = $urandom_range(0, 31);
        step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), a, $urandom_range(0, 255));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
